// File: rtl/letc_core_fetch_imem.sv
// Second fetch stage for the LETC core: synchronous instruction RAM with a 1- or 2-register
// read pipeline, stall/flush valid tracking, fault tagging, a load port and an optional NOP fill.
module letc_core_fetch_imem #(
    parameter int          DEPTH         = 1024,
    parameter int          PIPE_STAGES   = 2,
    parameter bit          FILL_ON_RESET = 1'b1,
    parameter logic [31:0] NOP_INSTR     = 32'h0000_0013,
    localparam int         AW            = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_stage_ready,
    input  logic          i_stage_flush,
    input  logic          i_stage_stall,
    input  logic          i_valid,
    input  logic [31:0]   i_fetch_addr,
    output logic          o_valid,
    output logic [31:0]   o_instr,
    output logic [31:0]   o_pc,
    output logic [1:0]    o_fault,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [31:0]   i_wr_data
);

    typedef enum logic {ST_FILL, ST_RUN} state_t;
    typedef enum logic [1:0] {FLT_NONE = 2'b00, FLT_MISALIGN = 2'b01, FLT_RANGE = 2'b10} fault_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        fault_t      fault;
        logic [31:0] data;
    } stage_t;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_fill_idx;
    logic          r_fill_done;
    logic          w_fill_we;
    logic          w_accept;
    logic [AW-1:0] w_word_idx;
    fault_t        w_fault;
    stage_t        r_s1;
    stage_t        w_out;

    // r_fill_done marks "last index written"; the state flips to RUN one cycle later.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= FILL_ON_RESET ? ST_FILL : ST_RUN;
            r_fill_idx  <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_fill_we) begin
                r_fill_idx <= r_fill_idx + 1'b1;
                if (r_fill_idx == AW'(DEPTH - 1)) r_fill_done <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_FILL && r_fill_done) w_state_next = ST_RUN;
    end

    assign w_fill_we     = (r_state == ST_FILL) && !r_fill_done && i_rst_n;
    assign o_stage_ready = (r_state == ST_RUN) && !i_stage_stall && i_rst_n;
    assign w_accept      = i_valid && o_stage_ready && !i_stage_flush;
    assign w_word_idx    = i_fetch_addr[AW+1:2];

    always_comb begin
        w_fault = FLT_NONE;
        if (i_fetch_addr[1:0] != 2'b00)          w_fault = FLT_MISALIGN;
        else if (i_fetch_addr[31:AW+2] != '0)    w_fault = FLT_RANGE;
    end

    // NOTE: the RAM array has no reset; only the FILL sequence initialises its contents.
    always_ff @(posedge i_clk) begin
        if (w_fill_we)
            r_mem[r_fill_idx] <= NOP_INSTR;
        else if (i_wr_en && r_state == ST_RUN && i_rst_n)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    // Read-first: the read below samples the array before a same-edge write lands.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
        end else if (i_stage_flush) begin
            r_s1.valid <= 1'b0;
        end else if (!i_stage_stall) begin
            r_s1.valid <= w_accept;
            r_s1.pc    <= i_fetch_addr;
            r_s1.fault <= w_fault;
            r_s1.data  <= r_mem[w_word_idx];
        end
    end

    if (PIPE_STAGES == 2) begin : g_pipe2
        stage_t r_s2;
        always_ff @(posedge i_clk) begin
            if (!i_rst_n)            r_s2       <= '0;
            else if (i_stage_flush)  r_s2.valid <= 1'b0;
            else if (!i_stage_stall) r_s2       <= r_s1;
        end
        assign w_out = r_s2;
    end else begin : g_pipe1
        assign w_out = r_s1;
    end

    assign o_valid = w_out.valid;
    assign o_pc    = w_out.pc;
    assign o_fault = w_out.fault;
    assign o_instr = (w_out.fault != FLT_NONE) ? NOP_INSTR : w_out.data;

endmodule

// File: tb/tb_letc_core_fetch_imem.sv
// Directed bench for letc_core_fetch_imem (DEPTH=16, two-stage read, fill on reset).
module tb_letc_core_fetch_imem;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          o_stage_ready;
    logic          i_stage_flush;
    logic          i_stage_stall;
    logic          i_valid;
    logic [31:0]   i_fetch_addr;
    logic          o_valid;
    logic [31:0]   o_instr;
    logic [31:0]   o_pc;
    logic [1:0]    o_fault;
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [31:0]   i_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    letc_core_fetch_imem #(
        .DEPTH(DEPTH), .PIPE_STAGES(2), .FILL_ON_RESET(1'b1), .NOP_INSTR(NOP)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_stage_ready(o_stage_ready),
        .i_stage_flush(i_stage_flush), .i_stage_stall(i_stage_stall),
        .i_valid(i_valid), .i_fetch_addr(i_fetch_addr),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_fault(o_fault),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data)
    );

    always #5 clk = ~clk;

    // Inputs change at the negedge; outputs are read at the next negedge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        i_valid = 1'b0; i_stage_stall = 1'b0; i_stage_flush = 1'b0; i_wr_en = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] instr,
                              input logic [31:0] pc, input logic [1:0] flt);
        n_checks++;
        if (o_valid !== v || (v && (o_instr !== instr || o_pc !== pc || o_fault !== flt))) begin
            n_fail++;
            $display("FAIL %s: got valid=%b instr=%h pc=%h fault=%b, expected valid=%b instr=%h pc=%h fault=%b",
                     name, o_valid, o_instr, o_pc, o_fault, v, instr, pc, flt);
        end
    endtask

    // Releases reset and checks ready stays low for DEPTH+1 cycles; pokes a write that must be ignored.
    task automatic run_fill(input string name);
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k == 10) begin
                i_wr_en = 1'b1; i_wr_addr = 4'd1; i_wr_data = 32'hBADB_AD00;
            end
            tick();
            n_checks++;
            if (o_stage_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ready cycle %0d: got %b expected 0", name, k, o_stage_ready);
            end
        end
        i_wr_en = 1'b0;
        tick();
        n_checks++;
        if (o_stage_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready rise: got %b expected 1", name, o_stage_ready);
        end
    endtask

    task automatic test_reset;
        idle();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({o_valid, o_stage_ready, o_fault, o_instr, o_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b ready=%b fault=%b instr=%h pc=%h expected all 0",
                     o_valid, o_stage_ready, o_fault, o_instr, o_pc);
        end
    endtask

    task automatic test_fill;
        run_fill("fill");
        i_valid = 1'b1; i_fetch_addr = 32'h3C; tick();
        i_fetch_addr = 32'h04; tick();
        expect_out("fill_last_word", 1'b1, NOP, 32'h3C, 2'b00);
        i_valid = 1'b0; tick();
        expect_out("fill_write_ignored", 1'b1, NOP, 32'h04, 2'b00);
    endtask

    task automatic test_streaming;
        i_wr_en = 1'b1; i_wr_addr = 4'd5; i_wr_data = 32'hDEAD_BEEF; tick();
        i_wr_addr = 4'd6; i_wr_data = 32'h1234_5678;
        i_valid = 1'b1; i_fetch_addr = 32'h14; tick();
        expect_out("stream_latency", 1'b0, 32'h0, 32'h0, 2'b00);
        i_wr_en = 1'b0; i_fetch_addr = 32'h18; tick();
        expect_out("stream_first", 1'b1, 32'hDEAD_BEEF, 32'h14, 2'b00);
        i_valid = 1'b0; tick();
        expect_out("stream_second", 1'b1, 32'h1234_5678, 32'h18, 2'b00);
        tick();
        expect_out("stream_drain", 1'b0, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic test_stall;
        i_valid = 1'b1; i_fetch_addr = 32'h14; tick();
        i_fetch_addr = 32'h18; tick();
        expect_out("stall_pre", 1'b1, 32'hDEAD_BEEF, 32'h14, 2'b00);
        i_stage_stall = 1'b1; i_fetch_addr = 32'h1C;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (o_stage_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready cycle %0d: got %b expected 0", k, o_stage_ready);
            end
            tick();
            expect_out("stall_frozen", 1'b1, 32'hDEAD_BEEF, 32'h14, 2'b00);
        end
        idle(); tick();
        expect_out("stall_release", 1'b1, 32'h1234_5678, 32'h18, 2'b00);
        tick();
        expect_out("stall_no_dup", 1'b0, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic test_flush;
        i_valid = 1'b1; i_fetch_addr = 32'h14; tick();
        i_fetch_addr = 32'h18; tick();
        expect_out("flush_pre", 1'b1, 32'hDEAD_BEEF, 32'h14, 2'b00);
        i_stage_flush = 1'b1; i_stage_stall = 1'b1; i_fetch_addr = 32'h1C; tick();
        expect_out("flush_cycle1", 1'b0, 32'h0, 32'h0, 2'b00);
        idle(); tick();
        expect_out("flush_cycle2", 1'b0, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic test_faults;
        i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_data = 32'hCAFE_F00D; tick();
        i_wr_en = 1'b0;
        i_valid = 1'b1; i_fetch_addr = 32'h16; tick();
        i_fetch_addr = 32'h40; tick();
        expect_out("fault_misaligned", 1'b1, NOP, 32'h16, 2'b01);
        i_fetch_addr = 32'h42; tick();
        expect_out("fault_range", 1'b1, NOP, 32'h40, 2'b10);
        i_fetch_addr = 32'h00; tick();
        expect_out("fault_both", 1'b1, NOP, 32'h42, 2'b01);
        i_valid = 1'b0; tick();
        expect_out("fault_clean", 1'b1, 32'hCAFE_F00D, 32'h00, 2'b00);
    endtask

    task automatic test_collision;
        i_wr_en = 1'b1; i_wr_addr = 4'd3; i_wr_data = 32'hA5A5_A5A5;
        i_valid = 1'b1; i_fetch_addr = 32'h0C; tick();
        i_wr_en = 1'b0; tick();
        expect_out("collide_old", 1'b1, NOP, 32'h0C, 2'b00);
        i_valid = 1'b0; tick();
        expect_out("collide_new", 1'b1, 32'hA5A5_A5A5, 32'h0C, 2'b00);
    endtask

    task automatic test_mid_reset;
        i_valid = 1'b1; i_fetch_addr = 32'h14; tick();
        i_fetch_addr = 32'h18; tick();
        expect_out("midrst_pre", 1'b1, 32'hDEAD_BEEF, 32'h14, 2'b00);
        rst_n = 1'b0; tick();
        n_checks++;
        if ({o_valid, o_stage_ready, o_fault, o_instr, o_pc} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got valid=%b ready=%b fault=%b instr=%h pc=%h expected all 0",
                     o_valid, o_stage_ready, o_fault, o_instr, o_pc);
        end
        idle();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0; tick();
        run_fill("refill");
        i_valid = 1'b1; i_fetch_addr = 32'h0C; tick();
        i_fetch_addr = 32'h14; tick();
        expect_out("refill_idx3", 1'b1, NOP, 32'h0C, 2'b00);
        i_valid = 1'b0; tick();
        expect_out("refill_idx5", 1'b1, NOP, 32'h14, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        i_fetch_addr = '0; i_wr_addr = '0; i_wr_data = '0;
        idle();
        test_reset();
        test_fill();
        test_streaming();
        test_stall();
        test_flush();
        test_faults();
        test_collision();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/letc_core_fetch_imem.md
# letc_core_fetch_imem

Parametrised second-fetch-stage instruction memory for the LETC core, sitting between F1 and D. It accepts a fetch address from F1, reads a synchronous on-chip instruction RAM through a configurable 1- or 2-register pipeline, and presents instruction, PC, valid and fault status to D. It adds the following over the first-generation fetch memory:
- stall and flush handling with valid tracking;
- misalignment and out-of-range detection;
- a runtime write (load) port;
- an optional post-reset NOP-fill sequencer.

## Interface
- DEPTH, 1024: instruction words in RAM; power of two, 16..65536; AW = log2(DEPTH).
- PIPE_STAGES, 2: read latency in cycles, 1 or 2.
- FILL_ON_RESET, 1: 1 = fill RAM with NOP after reset; 0 = no fill.
- NOP_INSTR, 32'h00000013: fill value and instruction substituted on fault.
- i_clk  in  1  core clock; the only clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- o_stage_ready  out  1  stage can accept a new fetch this cycle.
- i_stage_flush  in  1  kill all in-flight fetches.
- i_stage_stall  in  1  freeze the whole stage.
- i_valid  in  1  F1 presents a fetch.
- i_fetch_addr  in  32  byte address from F1.
- o_valid  out  1  output fields valid for D.
- o_instr  out  32  fetched instruction.
- o_pc  out  32  byte address of o_instr.
- o_fault  out  2  00 none, 01 misaligned, 10 out of range.
- i_wr_en  in  1  RAM write strobe.
- i_wr_addr  in  AW  RAM word index.
- i_wr_data  in  32  RAM write data.

## Operation

**FSM states:** FILL, RUN.
- Reset enters FILL when FILL_ON_RESET=1, otherwise RUN.
- FILL writes NOP_INSTR to word index 0..DEPTH-1, one index per cycle, using an AW-bit counter.
- FILL moves to RUN in the cycle after index DEPTH-1 is written.
- During FILL: o_stage_ready=0 and external writes (i_wr_en) are ignored.

**Accept and ready:**
- o_stage_ready = (state==RUN) && !i_stage_stall && i_rst_n.
- A fetch is accepted when i_valid && o_stage_ready && !i_stage_flush.

**Address decode:**
- Word index = i_fetch_addr[AW+1:2].
- Misaligned when i_fetch_addr[1:0] != 0.
- Out of range when i_fetch_addr[31:AW+2] != 0.
- If both conditions hold, misaligned wins.
- A faulting fetch still flows through the pipeline. Its o_instr = NOP_INSTR and o_fault is set; the RAM data is discarded.

**Pipeline:**
- Each stage register carries valid, pc and fault alongside the data.
- With PIPE_STAGES=2, the RAM output register feeds one extra data register.
- **Stall** (i_stage_stall=1, no flush): every stage register and the RAM read enable hold. Outputs stay constant.
- **Flush:** all valid bits clear at the next edge, including a fetch presented in the same cycle. Flush beats stall. Data and pc fields are don't-care once their valid is clear.

**Write port:**
- Active only in RUN; i_wr_en writes at the clock edge.
- Writes are accepted regardless of stall.
- A read and write to the same index in the same cycle returns the old data (read-first).

**Reset (mid-operation included):**
- All valid bits clear; o_valid=0, o_instr=0, o_pc=0, o_fault=0, o_stage_ready=0.
- FSM returns to FILL (or RUN) and the fill counter returns to 0.
- RAM contents are not cleared except by FILL.

## Timing
- Latency: a fetch accepted at edge N appears with o_valid=1 after edge N+PIPE_STAGES, provided no stall cycles intervene. Each stall cycle adds exactly one cycle.
- Throughput: one fetch per cycle in RUN without stall. There are no bubbles between back-to-back addresses.
- After reset deasserts with FILL_ON_RESET=1, o_stage_ready first rises DEPTH+1 cycles after the first edge with i_rst_n=1.
- A write at edge N is visible to a read accepted at edge N+1.
- o_stage_ready is combinational from i_stage_stall and state only. It has no path from i_valid or i_fetch_addr.

## Test plan
- **Fill:** reset with FILL_ON_RESET=1, DEPTH=16 -> o_stage_ready=0 for 17 cycles; fetch of 0x0000003C then returns 0x00000013 with o_fault=00.
- **Streaming:** write 0xDEADBEEF to index 5 and 0x12345678 to index 6; fetch 0x14 then 0x18 back-to-back with PIPE_STAGES=2 -> o_valid two edges after each accept; o_instr = 0xDEADBEEF then 0x12345678; o_pc = 0x14 then 0x18.
- **Stall:** hold i_stage_stall for 3 cycles with two fetches in flight -> outputs frozen and o_stage_ready=0 throughout; both instructions emerge in order, none lost or duplicated.
- **Flush:** assert i_stage_flush with both stages valid while i_valid=1 and stall=1 -> o_valid=0 on the next two cycles.
- **Faults:** fetch 0x00000016 -> o_fault=01, o_instr=0x00000013; with DEPTH=16, fetch 0x00000040 -> o_fault=10; fetch 0x00000042 -> o_fault=01.
- **Collision and reset:** same-cycle write 0xA5A5A5A5 and read of index 3 -> old value is returned, and the next read returns 0xA5A5A5A5. Reset asserted mid-stream -> all outputs 0 on the next edge and FILL restarts at index 0.
